// File: rtl/serial_reg_bridge.sv
// Byte-stream to register-bus bridge: decodes {wr, inc, cnt} packets from a serial
// receiver into register read/write requests and returns read data to the transmitter.
module serial_reg_bridge #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       new_rx_data,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    input  logic       tx_busy,
    output logic [5:0] reg_addr,
    output logic       write,
    output logic       new_req,
    output logic [7:0] write_value,
    input  logic [7:0] read_value
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RREQ,
        RWAIT,
        RSEND
    } state_t;

    state_t        state, state_d;
    logic          wr, wr_d;
    logic          inc, inc_d;
    logic [5:0]    cnt, cnt_d;
    logic [5:0]    addr, addr_d;
    logic [TW-1:0] timer, timer_d;

    logic [7:0]    tx_data_d;
    logic          new_tx_data_d;
    logic [5:0]    reg_addr_d;
    logic          write_d;
    logic          new_req_d;
    logic [7:0]    write_value_d;

    // Address advance after each issued request; 6-bit add wraps 3F -> 00.
    function automatic logic [5:0] step_addr(input logic [5:0] a, input logic do_inc);
        return do_inc ? a + 6'd1 : a;
    endfunction

    function automatic logic [TW-1:0] tick(input logic [TW-1:0] t);
        return t + TW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr          <= 1'b0;
            inc         <= 1'b0;
            cnt         <= '0;
            addr        <= '0;
            timer       <= '0;
            tx_data     <= '0;
            new_tx_data <= 1'b0;
            reg_addr    <= '0;
            write       <= 1'b0;
            new_req     <= 1'b0;
            write_value <= '0;
        end else begin
            state       <= state_d;
            wr          <= wr_d;
            inc         <= inc_d;
            cnt         <= cnt_d;
            addr        <= addr_d;
            timer       <= timer_d;
            tx_data     <= tx_data_d;
            new_tx_data <= new_tx_data_d;
            reg_addr    <= reg_addr_d;
            write       <= write_d;
            new_req     <= new_req_d;
            write_value <= write_value_d;
        end
    end

    always_comb begin
        state_d       = state;
        wr_d          = wr;
        inc_d         = inc;
        cnt_d         = cnt;
        addr_d        = addr;
        timer_d       = '0;
        tx_data_d     = tx_data;
        new_tx_data_d = 1'b0;
        reg_addr_d    = reg_addr;
        write_d       = write;
        new_req_d     = 1'b0;
        write_value_d = write_value;

        case (state)
            IDLE: begin
                if (new_rx_data) begin
                    wr_d    = rx_data[7];
                    inc_d   = rx_data[6];
                    cnt_d   = rx_data[5:0];
                    state_d = ADDR;
                end
            end

            ADDR: begin
                if (new_rx_data) begin
                    addr_d  = rx_data[5:0];
                    state_d = wr ? WDATA : RREQ;
                end else if (timer == TIMEOUT_VAL) begin
                    state_d = IDLE;
                end else begin
                    timer_d = tick(timer);
                end
            end

            WDATA: begin
                if (new_rx_data) begin
                    new_req_d     = 1'b1;
                    write_d       = 1'b1;
                    write_value_d = rx_data;
                    reg_addr_d    = addr;
                    addr_d        = step_addr(addr, inc);
                    if (cnt == 6'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt - 6'd1;
                    end
                end else if (timer == TIMEOUT_VAL) begin
                    // Abandon the packet; writes already issued are not undone.
                    state_d = IDLE;
                end else begin
                    timer_d = tick(timer);
                end
            end

            RREQ: begin
                new_req_d  = 1'b1;
                write_d    = 1'b0;
                reg_addr_d = addr;
                addr_d     = step_addr(addr, inc);
                state_d    = RWAIT;
            end

            RWAIT: begin
                // read_value is valid the cycle after the controller samples new_req,
                // i.e. once our registered strobe has dropped again.
                if (!new_req) begin
                    tx_data_d = read_value;
                    state_d   = RSEND;
                end
            end

            RSEND: begin
                if (!tx_busy) begin
                    new_tx_data_d = 1'b1;
                    if (cnt == 6'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt - 6'd1;
                        state_d = RREQ;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_reg_bridge.sv
// Scoreboard bench for serial_reg_bridge: expected requests and transmit bytes are queued
// as packets are driven and retired by a monitor as the DUT strobes them.
module tb_serial_reg_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       new_rx_data = 1'b0;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy = 1'b0;
    logic [5:0] reg_addr;
    logic       write;
    logic       new_req;
    logic [7:0] write_value;
    logic [7:0] read_value = 8'h00;

    typedef struct {
        logic       wr;
        logic [5:0] addr;
        logic [7:0] val;
        int         cyc;
    } req_t;

    req_t       exp_req[$];
    logic [7:0] exp_tx[$];
    logic [7:0] rsp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int req_cnt = 0;
    int tx_cnt = 0;
    logic prev_req = 1'b0;
    logic busy_at_edge = 1'b0;

    serial_reg_bridge #(.TIMEOUT_CYCLES(100)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy),
        .reg_addr    (reg_addr),
        .write       (write),
        .new_req     (new_req),
        .write_value (write_value),
        .read_value  (read_value)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        busy_at_edge <= tx_busy;
    end

    // Register-controller model: read data appears the cycle after new_req is sampled.
    always @(posedge clk) begin
        if (new_req === 1'b1 && write === 1'b0) begin
            if (rsp_q.size() > 0) read_value <= rsp_q.pop_front();
            else read_value <= 8'hEE;
        end
    end

    // Monitor: retire scoreboard entries as strobes appear.
    always @(negedge clk) begin
        req_t e;
        if (new_req === 1'b1) begin
            req_cnt++;
            checks++;
            if (prev_req) begin
                errors++;
                $display("FAIL req_pulse new_req high on consecutive cycles, required single-cycle");
            end
            if (exp_req.size() == 0) begin
                errors++;
                $display("FAIL req_unexpected got wr=%0d addr=%h val=%h, required no request",
                         write, reg_addr, write_value);
            end else begin
                e = exp_req.pop_front();
                if (write !== e.wr || reg_addr !== e.addr || (e.wr && write_value !== e.val) ||
                    (e.cyc >= 0 && cyc != e.cyc)) begin
                    errors++;
                    $display("FAIL req got wr=%0d addr=%h val=%h cyc=%0d, required wr=%0d addr=%h val=%h cyc=%0d",
                             write, reg_addr, write_value, cyc, e.wr, e.addr, e.val, e.cyc);
                end
            end
        end
        prev_req = (new_req === 1'b1);

        if (new_tx_data === 1'b1) begin
            tx_cnt++;
            checks++;
            if (busy_at_edge) begin
                errors++;
                $display("FAIL tx_busy new_tx_data pulsed while tx_busy=1, required hold");
            end
            if (exp_tx.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected got tx_data=%h, required no pulse", tx_data);
            end else if (tx_data !== exp_tx[0]) begin
                errors++;
                $display("FAIL tx_data got %h, required %h", tx_data, exp_tx[0]);
                void'(exp_tx.pop_front());
            end else begin
                void'(exp_tx.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
    endtask

    task automatic send_wbyte(input logic [5:0] a, input logic [7:0] v);
        req_t e;
        @(negedge clk);
        e.wr = 1'b1; e.addr = a; e.val = v; e.cyc = cyc + 1;
        exp_req.push_back(e);
        rx_data = v;
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
    endtask

    task automatic expect_read(input logic [5:0] a, input logic [7:0] v);
        req_t e;
        e.wr = 1'b0; e.addr = a; e.val = 8'h00; e.cyc = -1;
        exp_req.push_back(e);
        rsp_q.push_back(v);
        exp_tx.push_back(v);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && (exp_req.size() != 0 || exp_tx.size() != 0); i++)
            @(negedge clk);
        checks++;
        if (exp_req.size() != 0 || exp_tx.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d reqs %0d tx outstanding, required 0 0",
                     name, exp_req.size(), exp_tx.size());
            exp_req.delete();
            exp_tx.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({new_req, new_tx_data, write, reg_addr, write_value, tx_data} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b tx=%b wr=%b addr=%h wv=%h td=%h, required all 0",
                     new_req, new_tx_data, write, reg_addr, write_value, tx_data);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        send_byte(8'hC2);
        send_byte(8'h05);
        send_wbyte(6'h05, 8'hAA);
        send_wbyte(6'h06, 8'hBB);
        send_wbyte(6'h07, 8'hCC);
        drain("write");
    endtask

    task automatic test_read();
        expect_read(6'h3F, 8'h11);
        expect_read(6'h3F, 8'h22);
        send_byte(8'h01);
        send_byte(8'h3F);
        drain("read");
    endtask

    task automatic test_wrap();
        expect_read(6'h3F, 8'h5A);
        expect_read(6'h00, 8'hA5);
        send_byte(8'h41);
        send_byte(8'h3F);
        drain("wrap");
    endtask

    task automatic test_backpressure();
        int r0, t0, got;
        tx_busy = 1'b1;
        expect_read(6'h20, 8'h33);
        expect_read(6'h21, 8'h44);
        r0 = req_cnt;
        send_byte(8'h41);
        send_byte(8'h20);
        t0 = tx_cnt;
        send_byte(8'hC0);
        repeat (18) @(negedge clk);
        checks++;
        if (tx_cnt != t0) begin
            errors++;
            $display("FAIL bp_no_tx got %0d pulses while busy, required 0", tx_cnt - t0);
        end
        checks++;
        if (req_cnt - r0 != 1) begin
            errors++;
            $display("FAIL bp_one_req got %0d requests while busy, required 1", req_cnt - r0);
        end
        tx_busy = 1'b0;
        got = 0;
        for (int i = 0; i < 3 && tx_cnt == t0; i++) begin
            @(negedge clk);
            got = i + 1;
        end
        checks++;
        if (tx_cnt != t0 + 1) begin
            errors++;
            $display("FAIL bp_release got %0d pulses after %0d cycles, required 1", tx_cnt - t0, got);
        end
        checks++;
        if (req_cnt - r0 != 1) begin
            errors++;
            $display("FAIL bp_req_order got %0d requests before tx pulse, required 1", req_cnt - r0);
        end
        drain("backpressure");
    endtask

    task automatic test_timeout();
        int r0;
        r0 = req_cnt;
        send_byte(8'h81);
        send_byte(8'h10);
        repeat (110) @(negedge clk);
        checks++;
        if (req_cnt != r0) begin
            errors++;
            $display("FAIL timeout_noreq got %0d requests, required 0", req_cnt - r0);
        end
        send_byte(8'h80);
        send_byte(8'h02);
        send_wbyte(6'h02, 8'h55);
        drain("timeout");
    endtask

    task automatic test_reset_mid();
        send_byte(8'hC3);
        send_byte(8'h10);
        send_wbyte(6'h10, 8'h01);
        @(negedge clk);
        rx_data = 8'h02;
        new_rx_data = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
        checks++;
        if ({new_req, new_tx_data, write, reg_addr, write_value, tx_data} !== 24'h0) begin
            errors++;
            $display("FAIL reset_mid got req=%b tx=%b wr=%b addr=%h wv=%h td=%h, required all 0",
                     new_req, new_tx_data, write, reg_addr, write_value, tx_data);
        end
        rst = 1'b0;
        send_byte(8'h80);
        send_byte(8'h07);
        send_wbyte(6'h07, 8'h99);
        drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_reg_bridge.md
SERIAL_REG_BRIDGE -- requirements
Module: serial_reg_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, idle cycles allowed between received bytes of one packet before the packet is abandoned.
REQ-002 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port rx_data, input, 8, received serial byte.
REQ-005 SHALL have port new_rx_data, input, 1, one-cycle strobe qualifying rx_data.
REQ-006 SHALL have port tx_data, output, 8, byte to transmit.
REQ-007 SHALL have port new_tx_data, output, 1, one-cycle strobe qualifying tx_data.
REQ-008 SHALL have port tx_busy, input, 1, transmitter cannot accept a byte.
REQ-009 SHALL have port reg_addr, output, 6, register address to register controller.
REQ-010 SHALL have port write, output, 1, 1 = write request, 0 = read request.
REQ-011 SHALL have port new_req, output, 1, one-cycle request strobe.
REQ-012 SHALL have port write_value, output, 8, write data.
REQ-013 SHALL have port read_value, input, 8, read data; valid the cycle after new_req is sampled.

Function
REQ-014 Packet format SHALL be: byte0 = {wr, inc, cnt[5:0]}, byte1 = address (bits 7:6 ignored), then cnt+1 data bytes for writes only; transfer length 1..64.
REQ-015 All outputs SHALL be registered.
REQ-016 States SHALL be IDLE, ADDR, WDATA, RREQ, RWAIT, RSEND.
REQ-017 IDLE: on new_rx_data, latch wr, inc, cnt as remaining count, go to ADDR.
REQ-018 ADDR: on new_rx_data, latch rx_data[5:0] as address; go to WDATA if wr=1, else RREQ.
REQ-019 WDATA: on new_rx_data, the next cycle SHALL have new_req=1, write=1, write_value=rx_data, reg_addr=current address.
REQ-020 After each request, if inc=1 the address SHALL increment modulo 64 (6'h3F -> 6'h00); if inc=0 it SHALL hold.
REQ-021 After the request for the last byte (remaining count 0), the state SHALL go to IDLE; otherwise the remaining count SHALL decrement.
REQ-022 RREQ: assert new_req=1, write=0, reg_addr=current address for exactly one cycle, then go to RWAIT.
REQ-023 RWAIT: sample read_value into tx_data, then go to RSEND.
REQ-024 RSEND: in the first cycle with tx_busy=0, pulse new_tx_data for one cycle, then go to RREQ (count remaining) or IDLE (last byte); while tx_busy=1, hold and assert nothing.
REQ-025 new_req and new_tx_data SHALL never be high in two consecutive cycles from the same byte; write SHALL be stable while new_req=1.
REQ-026 new_rx_data SHALL be ignored in RREQ, RWAIT and RSEND; bytes arriving there SHALL be dropped.
REQ-027 Timeout counter SHALL clear on every new_rx_data and run only in ADDR and WDATA.
REQ-028 When the timeout counter reaches TIMEOUT_CYCLES, the state SHALL go to IDLE with no request issued for the pending byte; requests already issued SHALL stand.
REQ-029 Counter width SHALL cover TIMEOUT_CYCLES without overflow.

Reset
REQ-030 On rst=1 at a clock edge, state SHALL return to IDLE, and the counters, reg_addr, write, write_value, tx_data SHALL clear to 0.
REQ-031 On rst=1, new_req and new_tx_data SHALL be 0 in the following cycle, including when reset occurs mid-packet.

Verification
REQ-032 Write test: rx bytes 8'hC2, 8'h05, 8'hAA, 8'hBB, 8'hCC -> three write strobes, each one cycle after its byte: (addr 05, AA), (06, BB), (07, CC); then IDLE.
REQ-033 Read test: rx 8'h01, 8'h3F, inc=0, responder returns 8'h11 then 8'h22 -> two read strobes both at addr 3F; tx_data 11 then 22, each on one new_tx_data pulse.
REQ-034 Wrap test: rx 8'h41, 8'h3F with inc=1 -> read addresses 3F then 00.
REQ-035 Backpressure test: hold tx_busy=1 for 20 cycles during RSEND -> no new_tx_data while busy; one pulse in the first non-busy cycle; no second new_req before it.
REQ-036 Timeout test (TIMEOUT_CYCLES=100): rx 8'h81, 8'h10, then silence for 100 cycles -> no new_req; a following packet 8'h80, 8'h02, 8'h55 -> one write (02, 55).
REQ-037 Reset test: assert rst mid-WDATA -> outputs zero next cycle; the next packet decodes from byte0.
